// File: rtl/priority_decode.sv
// Priority decode: rebuilds the priority encoder's per-pad vpfs/cnts map from a
// (vpf, adr, cnt) cluster stream, one frame at a time between frame_i strobes.
module priority_decode #(
    parameter int MXKEYS     = 192,
    parameter int MXKEYBITS  = 8,
    parameter int MXCNTB     = 3,
    parameter int MXCLUSTERS = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     frame_i,
    input  logic                     vpf_i,
    input  logic [MXKEYBITS-1:0]     adr_i,
    input  logic [MXCNTB-1:0]        cnt_i,
    output logic [MXKEYS-1:0]        vpfs_o,
    output logic [MXKEYS*MXCNTB-1:0] cnts_o,
    output logic                     valid_o,
    output logic [3:0]               ncl_o,
    output logic                     overflow_o,
    output logic                     badadr_o
);

    localparam int NCLW = $clog2(MXCLUSTERS + 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                     state;
    logic [MXKEYS-1:0]          acc_vpfs, nxt_vpfs;
    logic [MXKEYS*MXCNTB-1:0]   acc_cnts, nxt_cnts;
    logic [NCLW-1:0]            acc_ncl, base_ncl, nxt_ncl;
    logic                       acc_ovf, nxt_ovf;
    logic                       acc_bad, nxt_bad;
    logic                       open_frame;
    logic                       adr_ok;

    function automatic logic [NCLW-1:0] sat_inc(input logic [NCLW-1:0] n);
        return (n >= NCLW'(MXCLUSTERS)) ? NCLW'(MXCLUSTERS) : n + NCLW'(1);
    endfunction

    // A cluster arriving with frame_i lands in the freshly cleared accumulator.
    always_comb begin
        open_frame = (state == ACCUM) || frame_i;
        adr_ok     = (32'(adr_i) < MXKEYS);
        nxt_vpfs   = frame_i ? '0 : acc_vpfs;
        nxt_cnts   = frame_i ? '0 : acc_cnts;
        base_ncl   = frame_i ? '0 : acc_ncl;
        nxt_ovf    = frame_i ? 1'b0 : acc_ovf;
        nxt_bad    = frame_i ? 1'b0 : acc_bad;
        nxt_ncl    = base_ncl;
        if (open_frame && vpf_i) begin
            if (!adr_ok) begin
                nxt_bad = 1'b1;
            end else if (base_ncl == NCLW'(MXCLUSTERS)) begin
                nxt_ovf = 1'b1;
            end else begin
                for (int k = 0; k < MXKEYS; k++) begin
                    if (32'(adr_i) == k) begin
                        nxt_vpfs[k]                   = 1'b1;
                        nxt_cnts[k*MXCNTB +: MXCNTB]  = cnt_i;
                    end
                end
                nxt_ncl = sat_inc(base_ncl);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            acc_vpfs   <= '0;
            acc_cnts   <= '0;
            acc_ncl    <= '0;
            acc_ovf    <= 1'b0;
            acc_bad    <= 1'b0;
            vpfs_o     <= '0;
            cnts_o     <= '0;
            ncl_o      <= '0;
            overflow_o <= 1'b0;
            badadr_o   <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (open_frame) begin
                state    <= ACCUM;
                acc_vpfs <= nxt_vpfs;
                acc_cnts <= nxt_cnts;
                acc_ncl  <= nxt_ncl;
                acc_ovf  <= nxt_ovf;
                acc_bad  <= nxt_bad;
            end
            // Only a strobe seen while accumulating closes a frame.
            if (frame_i && state == ACCUM) begin
                vpfs_o     <= acc_vpfs;
                cnts_o     <= acc_cnts;
                ncl_o      <= 4'(acc_ncl);
                overflow_o <= acc_ovf;
                badadr_o   <= acc_bad;
                valid_o    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_priority_decode.sv
// Self-checking bench for priority_decode with a cluster-list reference model.
module tb_priority_decode;

    localparam int MXKEYS = 192;
    localparam int MXCNTB = 3;
    localparam int MXCL   = 8;

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     frame_i = 1'b0;
    logic                     vpf_i = 1'b0;
    logic [7:0]               adr_i = '0;
    logic [2:0]               cnt_i = '0;
    logic [MXKEYS-1:0]        vpfs_o;
    logic [MXKEYS*MXCNTB-1:0] cnts_o;
    logic                     valid_o;
    logic [3:0]               ncl_o;
    logic                     overflow_o;
    logic                     badadr_o;

    int checks = 0;
    int passes = 0;

    // Reference model: accepted clusters of the open frame kept as a list.
    bit                       started;
    int                       cur_q[$];
    int                       closed_q[$];
    bit                       cur_ov, cur_bad;
    logic [MXKEYS-1:0]        exp_vpfs;
    logic [MXKEYS*MXCNTB-1:0] exp_cnts;
    int                       exp_ncl;
    bit                       exp_ov, exp_bad, exp_valid;

    priority_decode dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .frame_i    (frame_i),
        .vpf_i      (vpf_i),
        .adr_i      (adr_i),
        .cnt_i      (cnt_i),
        .vpfs_o     (vpfs_o),
        .cnts_o     (cnts_o),
        .valid_o    (valid_o),
        .ncl_o      (ncl_o),
        .overflow_o (overflow_o),
        .badadr_o   (badadr_o)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        started   = 0;
        cur_q.delete();
        closed_q.delete();
        cur_ov    = 0;
        cur_bad   = 0;
        exp_vpfs  = '0;
        exp_cnts  = '0;
        exp_ncl   = 0;
        exp_ov    = 0;
        exp_bad   = 0;
        exp_valid = 0;
    endtask

    // Drive one cycle, advance past the edge, and step the model.
    task automatic cyc(input bit f, input bit v, input int a, input int c);
        frame_i = f;
        vpf_i   = v;
        adr_i   = a[7:0];
        cnt_i   = c[2:0];
        @(posedge clock);
        #1;
        exp_valid = 0;
        if (f && started) begin
            exp_vpfs = '0;
            exp_cnts = '0;
            foreach (cur_q[i]) begin
                exp_vpfs[cur_q[i] / 8] = 1'b1;
                exp_cnts[(cur_q[i] / 8) * 3 +: 3] = 3'(cur_q[i] % 8);
            end
            closed_q  = cur_q;
            exp_ncl   = cur_q.size();
            exp_ov    = cur_ov;
            exp_bad   = cur_bad;
            exp_valid = 1;
        end
        if (f) begin
            started = 1;
            cur_q.delete();
            cur_ov  = 0;
            cur_bad = 0;
        end
        if (started && v) begin
            if (a >= MXKEYS) cur_bad = 1;
            else if (cur_q.size() >= MXCL) cur_ov = 1;
            else cur_q.push_back(a * 8 + c);
        end
        frame_i = 0;
        vpf_i   = 0;
    endtask

    task automatic test_reset();
        model_reset();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (vpfs_o !== '0) $display("FAIL reset_vpfs: got %0h want 0", vpfs_o); else passes++;
        checks++; if (cnts_o !== '0) $display("FAIL reset_cnts: got %0h want 0", cnts_o); else passes++;
        checks++; if ({valid_o, ncl_o, overflow_o, badadr_o} !== 7'd0)
            $display("FAIL reset_ctl: got valid=%b ncl=%0d ov=%b bad=%b want all 0", valid_o, ncl_o, overflow_o, badadr_o);
        else passes++;
        reset_n = 1;
    endtask

    task automatic test_basic();
        cyc(1, 0, 0, 0);
        checks++; if (valid_o !== 1'b0) $display("FAIL first_frame_valid: got %b want 0", valid_o); else passes++;
        cyc(0, 1, 5, 3);
        cyc(0, 1, 191, 7);
        cyc(1, 0, 0, 0);
        checks++; if (valid_o !== 1'b1) $display("FAIL basic_valid: got %b want 1", valid_o); else passes++;
        checks++; if (vpfs_o !== ((192'd1 << 5) | (192'd1 << 191)))
            $display("FAIL basic_vpfs: got %0h want bits 5,191", vpfs_o);
        else passes++;
        checks++; if (cnts_o[17:15] !== 3'd3) $display("FAIL basic_cnt5: got %0d want 3", cnts_o[17:15]); else passes++;
        checks++; if (cnts_o[575:573] !== 3'd7) $display("FAIL basic_cnt191: got %0d want 7", cnts_o[575:573]); else passes++;
        checks++; if (ncl_o !== 4'd2) $display("FAIL basic_ncl: got %0d want 2", ncl_o); else passes++;
        checks++; if ({overflow_o, badadr_o} !== 2'b00) $display("FAIL basic_flags: got %b want 00", {overflow_o, badadr_o}); else passes++;
        cyc(0, 1, 20, 1);
        checks++; if (valid_o !== 1'b0 || ncl_o !== 4'd2 || vpfs_o !== exp_vpfs)
            $display("FAIL basic_hold: got valid=%b ncl=%0d want valid=0 ncl=2 unchanged map", valid_o, ncl_o);
        else passes++;
    endtask

    task automatic test_overflow();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, i, $urandom_range(0, 7));
        cyc(1, 0, 0, 0);
        checks++; if (ncl_o !== 4'd8) $display("FAIL ovf_ncl: got %0d want 8", ncl_o); else passes++;
        checks++; if (vpfs_o !== 192'hFF) $display("FAIL ovf_vpfs: got %0h want ff", vpfs_o); else passes++;
        checks++; if (cnts_o !== exp_cnts) $display("FAIL ovf_cnts: got %0h want %0h", cnts_o, exp_cnts); else passes++;
        checks++; if ({overflow_o, badadr_o} !== 2'b10) $display("FAIL ovf_flags: got %b want 10", {overflow_o, badadr_o}); else passes++;
    endtask

    task automatic test_badadr();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 255, 4);
        cyc(0, 1, 192, 2);
        cyc(1, 0, 0, 0);
        checks++; if ({badadr_o, overflow_o} !== 2'b10) $display("FAIL bad_flags: got %b want 10", {badadr_o, overflow_o}); else passes++;
        checks++; if (ncl_o !== 4'd0) $display("FAIL bad_ncl: got %0d want 0", ncl_o); else passes++;
        checks++; if (vpfs_o !== '0) $display("FAIL bad_vpfs: got %0h want 0", vpfs_o); else passes++;
    endtask

    task automatic test_dup();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 3, 1);
        cyc(0, 0, 3, 5);
        cyc(0, 1, 3, 6);
        cyc(1, 0, 0, 0);
        checks++; if (cnts_o[11:9] !== 3'd6) $display("FAIL dup_cnt: got %0d want 6", cnts_o[11:9]); else passes++;
        checks++; if (ncl_o !== 4'd2 || vpfs_o !== (192'd1 << 3))
            $display("FAIL dup_ncl_map: got ncl=%0d map=%0h want ncl=2 map=8", ncl_o, vpfs_o);
        else passes++;
    endtask

    task automatic test_same_cycle();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 11, 4);
        cyc(1, 1, 10, 2);
        checks++; if (vpfs_o[10] !== 1'b0 || vpfs_o[11] !== 1'b1)
            $display("FAIL edge_closed: got bit10=%b bit11=%b want 0,1", vpfs_o[10], vpfs_o[11]);
        else passes++;
        cyc(1, 0, 0, 0);
        checks++; if (vpfs_o !== (192'd1 << 10) || cnts_o[32:30] !== 3'd2)
            $display("FAIL edge_next: got map=%0h cnt10=%0d want bit 10 cnt 2", vpfs_o, cnts_o[32:30]);
        else passes++;
    endtask

    task automatic test_back_to_back();
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        checks++; if (valid_o !== 1'b1 || vpfs_o !== '0 || cnts_o !== '0 || ncl_o !== 4'd0)
            $display("FAIL b2b_empty1: got valid=%b ncl=%0d want valid=1 empty", valid_o, ncl_o);
        else passes++;
        cyc(1, 0, 0, 0);
        checks++; if (valid_o !== 1'b1 || vpfs_o !== '0 || {overflow_o, badadr_o} !== 2'b00)
            $display("FAIL b2b_empty2: got valid=%b map=%0h want valid=1 empty", valid_o, vpfs_o);
        else passes++;
    endtask

    task automatic test_random();
        int len, a, lo, lo_cnt, dut_lo;
        bit v, f;
        for (int fr = 0; fr < 25; fr++) begin
            len = $urandom_range(0, 12);
            for (int i = 0; i <= len; i++) begin
                f = (i == len);
                v = ($urandom_range(0, 3) != 0);
                a = ($urandom_range(0, 9) == 0) ? $urandom_range(192, 255)
                  : (($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 191));
                cyc(f, v, a, $urandom_range(0, 7));
                checks++; if (valid_o !== exp_valid) $display("FAIL rnd_valid: got %b want %b", valid_o, exp_valid); else passes++;
            end
            checks++; if (vpfs_o !== exp_vpfs) $display("FAIL rnd_vpfs: got %0h want %0h", vpfs_o, exp_vpfs); else passes++;
            checks++; if (cnts_o !== exp_cnts) $display("FAIL rnd_cnts: got %0h want %0h", cnts_o, exp_cnts); else passes++;
            checks++; if (ncl_o !== 4'(exp_ncl) || overflow_o !== exp_ov || badadr_o !== exp_bad)
                $display("FAIL rnd_ctl: got ncl=%0d ov=%b bad=%b want ncl=%0d ov=%b bad=%b",
                         ncl_o, overflow_o, badadr_o, exp_ncl, exp_ov, exp_bad);
            else passes++;
            // Encoder round trip: lowest pad of the rebuilt map vs the model's lowest cluster.
            lo = 255;
            lo_cnt = 0;
            foreach (closed_q[i]) begin
                if (closed_q[i] / 8 < lo) lo = closed_q[i] / 8;
            end
            foreach (closed_q[i]) begin
                if (closed_q[i] / 8 == lo) lo_cnt = closed_q[i] % 8;
            end
            dut_lo = 255;
            for (int k = MXKEYS - 1; k >= 0; k--) if (vpfs_o[k]) dut_lo = k;
            checks++;
            if (dut_lo !== lo || (lo != 255 && int'(cnts_o[dut_lo*3 +: 3]) !== lo_cnt))
                $display("FAIL rnd_encoder: got adr=%0d want adr=%0d cnt=%0d", dut_lo, lo, lo_cnt);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        reset_n = 0;
        @(posedge clock);
        #1;
        model_reset();
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 40 + i, 5);
            checks++; if (valid_o !== 1'b0 || vpfs_o !== '0) $display("FAIL idle_ignore: got valid=%b map=%0h want 0", valid_o, vpfs_o); else passes++;
        end
        cyc(1, 0, 0, 0);
        checks++; if (valid_o !== 1'b0) $display("FAIL idle_frame: got valid=%b want 0", valid_o); else passes++;
        cyc(0, 1, 50, 3);
        cyc(0, 1, 60, 1);
        #2 reset_n = 0;
        #1;
        model_reset();
        checks++; if ({valid_o, ncl_o, overflow_o, badadr_o} !== 7'd0 || vpfs_o !== '0 || cnts_o !== '0)
            $display("FAIL midreset_out: got valid=%b ncl=%0d map=%0h want all 0", valid_o, ncl_o, vpfs_o);
        else passes++;
        @(posedge clock);
        #1 reset_n = 1;
        cyc(0, 1, 70, 2);
        cyc(1, 0, 0, 0);
        checks++; if (valid_o !== 1'b0 || vpfs_o !== '0) $display("FAIL midreset_rearm: got valid=%b map=%0h want 0", valid_o, vpfs_o); else passes++;
        cyc(0, 1, 7, 5);
        cyc(1, 0, 0, 0);
        checks++; if (valid_o !== 1'b1 || vpfs_o !== (192'd1 << 7) || cnts_o[23:21] !== 3'd5 || ncl_o !== 4'd1)
            $display("FAIL midreset_after: got valid=%b map=%0h ncl=%0d want valid=1 bit 7 cnt 5 ncl 1", valid_o, vpfs_o, ncl_o);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_badadr();
        test_dup();
        test_same_cycle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/priority_decode.md
PRIORITY_DECODE -- requirements
Module: priority_decode

Interface
REQ-001 Parameter MXKEYS, default 192: number of pad positions in the rebuilt map.
REQ-002 Parameter MXKEYBITS, default 8: address width.
REQ-003 Parameter MXCNTB, default 3: cluster count width.
REQ-004 Parameter MXCLUSTERS, default 8: maximum clusters accepted per frame.
REQ-005 clock  input  1  single clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 frame_i  input  1  frame boundary strobe: closes the current frame and opens a new one.
REQ-008 vpf_i  input  1  cluster valid.
REQ-009 adr_i  input  MXKEYBITS  cluster pad address.
REQ-010 cnt_i  input  MXCNTB  cluster count.
REQ-011 vpfs_o  output  MXKEYS  rebuilt per-pad valid map; bit k set means a cluster at pad k.
REQ-012 cnts_o  output  MXKEYS*MXCNTB  rebuilt counts; pad k in bits [k*3+2:k*3], the same packing as the priority encoder input.
REQ-013 valid_o  output  1  one-cycle strobe: the frame outputs are updated.
REQ-014 ncl_o  output  4  number of clusters accepted in the closed frame.
REQ-015 overflow_o  output  1  at least one cluster was dropped because the frame was full.
REQ-016 badadr_o  output  1  at least one cluster was dropped because its address was out of range.

Function
REQ-017 The block SHALL be the inverse of the priority encoder: it SHALL rebuild the encoder's vpfs/cnts input format from a stream of (vpf, adr, cnt) clusters, one per clock.
REQ-018 FSM states: IDLE and ACCUM.
  - IDLE: reset state; clusters are ignored.
  - IDLE -> ACCUM on the first frame_i=1.
  - ACCUM stays in ACCUM.
REQ-019 In ACCUM, a cluster SHALL be accepted when all of these hold: vpf_i=1, adr_i<MXKEYS and the accumulator cluster count <MXCLUSTERS.
REQ-020 On acceptance, the following SHALL update at the next edge:
  - accumulator vpf bit adr_i set to 1;
  - accumulator count field adr_i loaded with cnt_i;
  - accumulator cluster count incremented by 1.
REQ-021 Duplicate address within a frame: vpf bit stays 1, count field takes the later cnt_i, cluster count still increments.
REQ-022 vpf_i=1 with adr_i>=MXKEYS (including the encoder's 0xFF "no cluster" key): cluster dropped; sticky badadr flag set for the frame; cluster count unchanged.
REQ-023 vpf_i=1 with valid address and cluster count==MXCLUSTERS: cluster dropped; sticky overflow flag set for the frame.
  - If the address is also out of range, only badadr is set.
REQ-024 vpf_i=0: no change; adr_i and cnt_i are ignored.
REQ-025 frame_i=1 in ACCUM: at the next edge the accumulator (vpf map, counts, cluster count, overflow, badadr) SHALL transfer to the outputs, and valid_o SHALL be 1 for exactly that cycle.
REQ-026 frame_i=1 in IDLE: no output update; valid_o stays 0.
REQ-027 A cluster presented in the same cycle as frame_i SHALL belong to the new frame.
  - The accumulator clears, then that cluster is applied.
  - The closed frame SHALL NOT contain it.
REQ-028 Latency: frame_i at edge N -> outputs and valid_o visible after edge N+1. Clusters SHALL have zero bubble across frame boundaries.
REQ-029 Outputs SHALL hold their values until the next frame closure.
REQ-030 Back-to-back frame_i: each strobe closes a frame; an empty frame outputs all-zero maps with valid_o=1.
REQ-031 ncl_o saturates at MXCLUSTERS and never wraps.

Reset
REQ-032 While reset_n=0, the block SHALL be in IDLE with all of these cleared:
  - the accumulator;
  - vpfs_o, cnts_o, ncl_o, overflow_o, badadr_o and valid_o, all 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame without any valid_o.
  - After release, clusters are ignored until the next frame_i.
REQ-034 Reset release SHALL be synchronised by the parent; the block needs no internal release synchroniser.

Verification
REQ-035 Reset, then frame_i, then clusters (adr 5, cnt 3) and (adr 191, cnt 7), then frame_i -> valid_o=1; vpfs_o bits 5 and 191 set; cnts_o[17:15]=3; cnts_o[575:573]=7; ncl_o=2; both flags 0.
REQ-036 Nine valid clusters at adr 0..8 in one frame -> ncl_o=8; vpfs_o bits 0..7 set, bit 8 clear; overflow_o=1.
REQ-037 Cluster at adr 0xFF, then adr 192 -> badadr_o=1; ncl_o=0; vpfs_o=0.
REQ-038 Cluster (adr 10, cnt 2) in the same cycle as frame_i -> closed frame lacks bit 10; the following frame has bit 10 with count 2.
REQ-039 Clusters before the first frame_i, then reset asserted mid-frame -> no valid_o; all outputs 0.
REQ-040 Random clusters fed through the priority encoder round trip -> the encoder's adr/cnt matches the lowest set pad of vpfs_o.
